// File: rtl/mdr_mem_port_if.sv
// Control-unit / bus / RAM signal bundle for mdr_mem_port; the slave side is the port block.
// The master side holds both the control strobes and the memory response.
interface mdr_mem_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              mar_in;
  logic              mdr_in;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] mdr_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output BusMuxOut, mar_in, mdr_in, read, write, mem_rdata, mem_ack,
    input  mdr_q, mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, err
  );

  modport slave (
    input  BusMuxOut, mar_in, mdr_in, read, write, mem_rdata, mem_ack,
    output mdr_q, mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, err
  );
endinterface

// File: rtl/mdr_mem_port.sv
// MAR/MDR plus request/ack handshake to multi-cycle RAM; request held 1..TIMEOUT cycles, done one cycle after ack.
// While busy, all control strobes are ignored (no queuing); a missing ack aborts with sticky err.
module mdr_mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input logic           clock,
  input logic           clear,
  mdr_mem_port_if.slave mp
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // exactly one of read/write starts an access; both together is a conflict
  logic              start;
  assign start = mp.read ^ mp.write;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      cnt    <= '0;
      mar    <= '0;
      mdr    <= '0;
      addr_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mp.mar_in)
            mar <= mp.BusMuxOut[ADDR_W-1:0];
          if (mp.mdr_in && !start)
            mdr <= mp.BusMuxOut;
          if (mp.read && mp.write) begin
            err_q <= 1'b1;
          end else if (start) begin
            // request uses MAR as it stood before this edge
            addr_q <= mar;
            rd_q   <= mp.read;
            wr_q   <= mp.write;
            busy_q <= 1'b1;
            cnt    <= '0;
            state  <= mp.read ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          // ack on the limit edge still wins over the timeout
          if (mp.mem_ack) begin
            if (state == RD_WAIT)
              mdr <= mp.mem_rdata;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mp.mdr_q     = mdr;
  assign mp.mem_wdata = mdr;
  assign mp.mem_addr  = addr_q;
  assign mp.mem_rd    = rd_q;
  assign mp.mem_wr    = wr_q;
  assign mp.busy      = busy_q;
  assign mp.done      = done_q;
  assign mp.err       = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Randomized bench for mdr_mem_port: driver pushes expected access outcomes, a negedge monitor
// observes each request window on the memory side and compares against the queue.
module tb_mdr_mem_port;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                cycles;
    bit                done;
    logic [DATA_W-1:0] mdr;
    bit                err;
  } exp_t;

  logic clock;
  logic clear;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  logic [ADDR_W-1:0] m_mar;
  logic [DATA_W-1:0] m_mdr;
  bit                m_err;

  mdr_mem_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  mdr_mem_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .clear (clear),
    .mp    (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit                mon_active = 1'b0;
  int                mon_cnt;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_wdata;
  logic              mon_wr;
  bit                mon_stable;
  exp_t              mon_e;

  always @(negedge clock) begin
    if (!clear) begin
      mon_active = 1'b0;
    end else begin
      chk("busy_vs_req", bus_if.busy, bus_if.mem_rd | bus_if.mem_wr);
      if ((bus_if.mem_rd | bus_if.mem_wr) && !mon_active) begin
        mon_active = 1'b1;
        mon_cnt    = 1;
        mon_addr   = bus_if.mem_addr;
        mon_wdata  = bus_if.mem_wdata;
        mon_wr     = bus_if.mem_wr;
        mon_stable = (bus_if.mem_rd ^ bus_if.mem_wr);
      end else if (bus_if.mem_rd | bus_if.mem_wr) begin
        mon_cnt++;
        if (bus_if.mem_addr !== mon_addr || bus_if.mem_wdata !== mon_wdata ||
            bus_if.mem_wr !== mon_wr)
          mon_stable = 1'b0;
      end else if (mon_active) begin
        mon_active = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_access", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("req_kind", mon_wr, mon_e.is_wr);
          chk("req_addr", mon_addr, mon_e.addr);
          chk("req_wdata", mon_wdata, mon_e.wdata);
          chk("req_cycles", mon_cnt, mon_e.cycles);
          chk("req_stable", mon_stable, 1);
          chk("done_pulse", bus_if.done, mon_e.done);
          chk("mdr_after", bus_if.mdr_q, mon_e.mdr);
          chk("err_after", bus_if.err, mon_e.err);
        end
      end else begin
        chk("done_idle", bus_if.done, 0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.mar_in = 1'b0;
    bus_if.mdr_in = 1'b0;
    bus_if.read   = 1'b0;
    bus_if.write  = 1'b0;
  endtask

  task automatic load_mar(input logic [DATA_W-1:0] v);
    bus_if.mar_in    = 1'b1;
    bus_if.BusMuxOut = v;
    tick();
    bus_if.mar_in = 1'b0;
    m_mar = v[ADDR_W-1:0];
  endtask

  task automatic load_mdr(input logic [DATA_W-1:0] v);
    bus_if.mdr_in    = 1'b1;
    bus_if.BusMuxOut = v;
    tick();
    bus_if.mdr_in = 1'b0;
    m_mdr = v;
    chk("mdr_load", bus_if.mdr_q, m_mdr);
  endtask

  // n = wait cycle on which ack arrives (1..), 0 = never ack (timeout)
  task automatic access(input bit is_wr, input int n, input logic [DATA_W-1:0] rd,
                        input bit with_mar, input bit junk);
    exp_t e;
    logic [DATA_W-1:0] bus_v;
    e.is_wr  = is_wr;
    e.addr   = m_mar;
    e.wdata  = m_mdr;
    e.cycles = (n == 0) ? TIMEOUT : n;
    e.done   = (n != 0);
    e.mdr    = (!is_wr && n != 0) ? rd : m_mdr;
    e.err    = m_err | (n == 0);
    q.push_back(e);
    bus_v            = $urandom;
    bus_if.BusMuxOut = bus_v;
    bus_if.read      = !is_wr;
    bus_if.write     = is_wr;
    bus_if.mar_in    = with_mar;
    bus_if.mdr_in    = junk;
    tick();
    idle_inputs();
    if (with_mar) m_mar = bus_v[ADDR_W-1:0];
    m_mdr = e.mdr;
    m_err = e.err;
    for (int i = 1; i <= e.cycles; i++) begin
      if (junk) begin
        bus_if.BusMuxOut = (i % 2 == 0) ? '0 : DATA_W'($urandom);
        bus_if.mar_in    = 1'($urandom);
        bus_if.mdr_in    = 1'($urandom);
        bus_if.read      = 1'($urandom);
        bus_if.write     = 1'($urandom);
      end
      if (i == n) begin
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = rd;
      end
      tick();
      bus_if.mem_ack = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic idle_ack();
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = $urandom;
    tick();
    bus_if.mem_ack = 1'b0;
  endtask

  initial begin
    int op;
    int n;
    clear              = 1'b0;
    bus_if.BusMuxOut   = '0;
    bus_if.mem_rdata   = '0;
    bus_if.mem_ack     = 1'b0;
    idle_inputs();
    m_mar = '0;
    m_mdr = '0;
    m_err = 1'b0;
    #12;
    chk("rst_mdr", bus_if.mdr_q, 0);
    chk("rst_addr", bus_if.mem_addr, 0);
    chk("rst_rdwr", {bus_if.mem_rd, bus_if.mem_wr}, 0);
    chk("rst_flags", {bus_if.busy, bus_if.done, bus_if.err}, 0);
    @(negedge clock);
    clear = 1'b1;
    tick();

    // load and drive, then reads/writes from the bring-up plan
    load_mar(32'h0000_0123);
    load_mdr(32'hDEAD_BEEF);
    chk("busy_after_load", bus_if.busy, 0);
    access(1'b0, 3, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    load_mdr(32'hA5A5_A5A5);
    access(1'b1, 2, 32'h0, 1'b0, 1'b1);
    tick();
    chk("mdr_after_write", bus_if.mdr_q, 32'hA5A5_A5A5);
    access(1'b0, 0, 32'hFFFF_0000, 1'b0, 1'b0);
    tick();
    access(1'b0, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
    tick();
    access(1'b0, TIMEOUT, 32'h5555_AAAA, 1'b0, 1'b0);
    tick();

    // read+write conflict
    bus_if.read  = 1'b1;
    bus_if.write = 1'b1;
    tick();
    idle_inputs();
    m_err = 1'b1;
    chk("conflict_err", bus_if.err, 1);
    chk("conflict_noreq", {bus_if.mem_rd, bus_if.mem_wr, bus_if.busy}, 0);
    tick();
    // mar_in alongside read: old MAR requested, new MAR used next
    access(1'b0, 2, 32'h7777_1111, 1'b1, 1'b0);
    access(1'b1, 1, 32'h0, 1'b0, 1'b0);
    tick();

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 5);
      n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      case (op)
        0: load_mar($urandom);
        1: load_mdr($urandom);
        2, 3: access(1'b0, n, $urandom, 1'($urandom), 1'($urandom));
        4: access(1'b1, n, $urandom, 1'($urandom), 1'($urandom));
        default: idle_ack();
      endcase
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    tick();

    // reset in the middle of a read
    bus_if.read = 1'b1;
    tick();
    idle_inputs();
    tick();
    #2;
    clear = 1'b0;
    #1;
    chk("arst_rdwr", {bus_if.mem_rd, bus_if.mem_wr}, 0);
    chk("arst_flags", {bus_if.busy, bus_if.done, bus_if.err}, 0);
    chk("arst_mdr_addr", {bus_if.mdr_q, 23'h0, bus_if.mem_addr}, 0);
    m_mar = '0;
    m_mdr = '0;
    m_err = 1'b0;
    tick();
    clear = 1'b1;
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("post_rst_ack_ignored", {bus_if.busy, bus_if.done, bus_if.mem_rd}, 0);
    chk("post_rst_mdr", bus_if.mdr_q, 0);
    tick();
    access(1'b0, 2, 32'h1357_9BDF, 1'b0, 1'b0);
    tick();

    for (int w = 0; w < 50 && q.size() != 0; w++) tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdr_mem_port.md
# mdr_mem_port

Memory-side port of the datapath: holds the Memory Address Register (MAR) and Memory Data Register (MDR), and runs the request/acknowledge handshake with multi-cycle RAM. The MDR can be loaded either from the shared bus or from memory read data. Its contents drive one bus-mux input and memory write data, so the block also carries data out toward the bus, unlike plain bus-loaded registers. A wait-state FSM with a timeout sits between the control unit's read/write strobes and the memory.

## Interface
- DATA_W, 32, data width of bus, MDR and memory data
- ADDR_W, 9, memory address width; MAR holds BusMuxOut[ADDR_W-1:0]
- TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (≥2)

- clock  input  1  single clock; all state updates on posedge
- clear  input  1  asynchronous, active-low reset
- BusMuxOut  input  DATA_W  shared bus value
- mar_in  input  1  load MAR from bus
- mdr_in  input  1  load MDR from bus
- read  input  1  start memory read at MAR into MDR
- write  input  1  start memory write of MDR to MAR
- mdr_q  output  DATA_W  MDR contents (bus-mux source)
- mem_addr  output  ADDR_W  registered request address
- mem_wdata  output  DATA_W  write data (equals mdr_q)
- mem_rd  output  1  read request, held until ack or abort
- mem_wr  output  1  write request, held until ack or abort
- mem_rdata  input  DATA_W  read data, valid with mem_ack
- mem_ack  input  1  memory completion, one cycle
- busy  output  1  high in any wait state
- done  output  1  one-cycle pulse after a successful access
- err  output  1  sticky: timeout or read+write conflict

## Operation
- Reset (clear=0, asynchronous): MAR=0, MDR=0, mem_addr=0, mem_rd=mem_wr=0, busy=0, done=0, err=0, timeout counter=0, state=IDLE.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, read=1 and write=0:
  - Capture mem_addr ← MAR (the value before this edge).
  - Set mem_rd=1 and busy=1.
  - Go to RD_WAIT.
- IDLE, write=1 and read=0: same, but set mem_wr=1 and go to WR_WAIT. mem_wdata is the current MDR.
- IDLE, read=1 and write=1: no access; set err=1; stay in IDLE.
- IDLE, mar_in=1: MAR ← BusMuxOut[ADDR_W-1:0]. This is honoured even when read/write is asserted in the same cycle; the request still uses the old MAR.
- IDLE, mdr_in=1: MDR ← BusMuxOut, unless a read or write starts in the same cycle. In that case mdr_in is ignored.
- RD_WAIT, mem_ack=1:
  - MDR ← mem_rdata.
  - mem_rd=0, busy=0, done=1 for one cycle.
  - Go to IDLE.
- WR_WAIT, mem_ack=1: mem_wr=0, busy=0, done=1; go to IDLE. MDR is unchanged.
- Wait states, no ack: counter increments.
  - When the counter reaches TIMEOUT-1 with no ack: drop the request, set err=1, busy=0, done=0.
  - Go to IDLE; MDR unchanged.
- While busy: mar_in, mdr_in, read and write are ignored. MAR and MDR are frozen, so mem_wdata stays stable for the whole write.
- mem_ack in IDLE is ignored.
- err clears only on reset.
- Counter resets to 0 on every entry into a wait state.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Request strobe sampled at edge E0. mem_rd/mem_wr and busy are high from E0 onward.
- mem_ack sampled high at edge Ek (k≥1):
  - At Ek: MDR updates and busy/mem_rd/mem_wr drop.
  - done is high for exactly the cycle after Ek.
- Minimum access: ack in the first wait cycle gives 1 wait cycle; a new request is accepted at Ek+1.
- Timeout: the request is high for exactly TIMEOUT cycles, then err rises together with busy falling.
- An ack arriving on the same edge as the timeout limit counts as success: no err.
- Reset asserted mid-access: immediate return to reset values; the pending ack is dropped.

## Test plan
- Load and drive: mar_in with BusMuxOut=0x0000_0123, then mdr_in with 0xDEAD_BEEF → MAR=0x123 and mdr_q=0xDEAD_BEEF on the next cycle; busy=0.
- Read with 3-cycle wait: read pulse, mem_ack on the 3rd wait cycle with mem_rdata=0x1234_5678 →
  - mem_addr=0x123 and mem_rd high for 3 cycles.
  - mdr_q=0x1234_5678, done pulses once, err=0.
- Write with stable data: MDR=0xA5A5_A5A5, write pulse, toggle mdr_in with bus=0 while busy, ack after 2 cycles →
  - mem_wr high for 2 cycles with mem_wdata=0xA5A5_A5A5 throughout.
  - MDR unchanged.
- Timeout: read with no ack (TIMEOUT=15) →
  - mem_rd high for exactly 15 cycles, then err=1, busy=0, done=0.
  - MDR unchanged; a later successful read completes with err still 1.
- Conflicts: read=write=1 in IDLE → no request, err=1. mar_in=1 with read=1 → request uses the old MAR, and MAR holds the new value afterwards.
- Reset mid-read: clear low during RD_WAIT → all outputs return to 0 asynchronously. An ack after release is ignored and the block stays in IDLE.
